// File: rtl/usb_rx_ctrl.sv
// Receive control FSM for the USB 1.1 receiver: sequences SYNC, PID, data and EOP,
// checks the PID, bounds the data length and aborts stalled packets on a bit timeout.
module usb_rx_ctrl #(
   parameter logic [7:0] SYNC_BYTE      = 8'h80,
   parameter int         MAX_DATA_BYTES = 64,
   parameter bit         PID_CHECK_EN   = 1'b1,
   parameter int         TIMEOUT_CYCLES = 32,
   parameter int         CNT_W          = $clog2(MAX_DATA_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_edge,
   input  logic             shift_en,
   input  logic             byte_rcvd,
   input  logic             eop,
   input  logic [7:0]       rcv_data,
   output logic             rcving,
   output logic             w_enable,
   output logic             pid_set,
   output logic             pid_rst,
   output logic [3:0]       pid,
   output logic             r_error,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             pkt_done
);

   localparam int               TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BYTES);

   typedef enum logic [3:0] {
      IDLE, SYNC, PID_WAIT, PID_RCV, PID_WRITE, PID_CHECK, DATA_WAIT,
      DATA_RCV, DATA_WRITE, EOP, ERR, ERR_EOP, ERR_IDLE
   } state_t;

   state_t           state_reg, state_next;
   logic [7:0]       pid_reg;
   logic [2:0]       err_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [TO_W-1:0]  to_reg, to_next;
   logic             done_reg;
   logic             err_set;
   logic [2:0]       err_val;
   logic             timed, to_hit, enter_sync;

   always_comb begin
      state_next = state_reg;
      err_set    = 1'b0;
      err_val    = 3'd0;
      timed      = (state_reg == SYNC) || (state_reg == PID_WAIT) || (state_reg == PID_RCV) ||
                   (state_reg == DATA_WAIT) || (state_reg == DATA_RCV);
      // Saturating compare: a byte event may win on the last cycle and carry the count on.
      to_hit     = timed && !shift_en && (to_reg >= TO_LAST);
      unique case (state_reg)
         IDLE:      if (d_edge) state_next = SYNC;
         SYNC: begin
            if (byte_rcvd) begin
               if (rcv_data == SYNC_BYTE) state_next = PID_WAIT;
               else begin state_next = ERR; err_set = 1'b1; err_val = 3'd1; end
            end else if (to_hit) begin
               state_next = ERR_IDLE; err_set = 1'b1; err_val = 3'd5;
            end
         end
         PID_WAIT: begin
            if (shift_en) begin
               if (eop) begin state_next = ERR_EOP; err_set = 1'b1; err_val = 3'd3; end
               else state_next = PID_RCV;
            end else if (to_hit) begin
               state_next = ERR_IDLE; err_set = 1'b1; err_val = 3'd5;
            end
         end
         PID_RCV: begin
            if (eop && shift_en) begin
               state_next = ERR_EOP; err_set = 1'b1; err_val = 3'd3;
            end else if (byte_rcvd) state_next = PID_WRITE;
            else if (to_hit) begin
               state_next = ERR_IDLE; err_set = 1'b1; err_val = 3'd5;
            end
         end
         PID_WRITE: state_next = PID_CHECK;
         PID_CHECK: begin
            if (PID_CHECK_EN && (pid_reg[7:4] != ~pid_reg[3:0])) begin
               state_next = ERR; err_set = 1'b1; err_val = 3'd2;
            end else state_next = DATA_WAIT;
         end
         DATA_WAIT: begin
            if (shift_en) state_next = eop ? EOP : DATA_RCV;
            else if (to_hit) begin
               state_next = ERR_IDLE; err_set = 1'b1; err_val = 3'd5;
            end
         end
         DATA_RCV: begin
            if (eop && shift_en) begin
               state_next = ERR_EOP; err_set = 1'b1; err_val = 3'd3;
            end else if (byte_rcvd) begin
               if (cnt_reg == CNT_MAX) begin state_next = ERR; err_set = 1'b1; err_val = 3'd4; end
               else state_next = DATA_WRITE;
            end else if (to_hit) begin
               state_next = ERR_IDLE; err_set = 1'b1; err_val = 3'd5;
            end
         end
         DATA_WRITE: state_next = DATA_WAIT;
         EOP:        if (d_edge) state_next = IDLE;
         ERR:        if (eop && shift_en) state_next = ERR_EOP;
         ERR_EOP:    if (d_edge) state_next = ERR_IDLE;
         ERR_IDLE:   if (d_edge) state_next = SYNC;
         default:    state_next = IDLE;
      endcase
      enter_sync = (state_next == SYNC) && (state_reg != SYNC);
      if (!timed || shift_en) to_next = '0;
      else if (to_reg >= TO_LAST) to_next = to_reg;
      else to_next = to_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         pid_reg   <= '0;
         err_reg   <= '0;
         cnt_reg   <= '0;
         to_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         to_reg    <= to_next;
         done_reg  <= (state_next == EOP) && (state_reg != EOP);
         if (enter_sync) begin
            pid_reg <= '0;
            err_reg <= '0;
            cnt_reg <= '0;
         end else begin
            if (state_reg == PID_WRITE) pid_reg <= rcv_data;
            // First error of a packet is kept until the next SYNC.
            if (err_set && (err_reg == 3'd0)) err_reg <= err_val;
            if ((state_reg == DATA_WRITE) && (cnt_reg != CNT_MAX)) cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign rcving   = !((state_reg == IDLE) || (state_reg == EOP) ||
                       (state_reg == ERR_EOP) || (state_reg == ERR_IDLE));
   assign w_enable = (state_reg == DATA_WRITE);
   assign pid_set  = (state_reg == PID_WRITE);
   assign pid_rst  = (state_reg == SYNC);
   assign r_error  = (state_reg == ERR) || (state_reg == ERR_EOP) || (state_reg == ERR_IDLE);
   assign pid      = pid_reg[3:0];
   assign err_code = err_reg;
   assign byte_cnt = cnt_reg;
   assign pkt_done = done_reg;

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Parametrised receive control unit for the USB 1.1 receiver. It sequences one packet per frame through SYNC, PID, data bytes and EOP. It checks the PID internally, counts data bytes against a configurable maximum, and detects stalled lines with a bit-period timeout. It reports sticky error codes to the protocol layer and a completion pulse when a packet ends cleanly. It sits between the shift register, edge detector and EOP detector on one side and the RX FIFO and PID register on the other.

## Interface
- SYNC_BYTE, 8'h80: byte value required for a valid SYNC field.
- MAX_DATA_BYTES, 64: maximum data bytes accepted per packet (1..1023).
- PID_CHECK_EN, 1: 1 checks PID[7:4] == ~PID[3:0]; 0 skips the check.
- TIMEOUT_CYCLES, 32: consecutive clk cycles without shift_en that abort a packet (2..65535).
- CNT_W, $clog2(MAX_DATA_BYTES+1): width of byte_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- d_edge  in  1  line transition detected.
- shift_en  in  1  one-cycle strobe per sampled bit.
- byte_rcvd  in  1  one-cycle strobe when 8 bits have been assembled.
- eop  in  1  EOP line condition present.
- rcv_data  in  8  assembled byte, valid with byte_rcvd and for the following cycle.
- rcving  out  1  packet reception in progress.
- w_enable  out  1  one-cycle FIFO write strobe per data byte.
- pid_set  out  1  one-cycle PID register load strobe.
- pid_rst  out  1  PID register clear.
- pid  out  4  captured PID[3:0].
- r_error  out  1  error-recovery in progress.
- err_code  out  3  sticky cause of the last error: 0 none, 1 bad SYNC, 2 bad PID, 3 early EOP, 4 overflow, 5 timeout.
- byte_cnt  out  CNT_W  data bytes written in the current packet.
- pkt_done  out  1  one-cycle pulse on a clean end of packet.

## Operation
States: IDLE, SYNC, PID_WAIT, PID_RCV, PID_WRITE, PID_CHECK, DATA_WAIT, DATA_RCV, DATA_WRITE, EOP, ERR, ERR_EOP, ERR_IDLE.

Transitions:
- IDLE: d_edge -> SYNC.
- SYNC: on byte_rcvd, rcv_data == SYNC_BYTE -> PID_WAIT; any other value -> ERR with code 1.
- PID_WAIT: on shift_en, ~eop -> PID_RCV; eop -> ERR_EOP with code 3.
- PID_RCV: eop&&shift_en -> ERR_EOP with code 3; otherwise byte_rcvd -> PID_WRITE. EOP takes priority over byte_rcvd.
- PID_WRITE: captures rcv_data into pid_q; always -> PID_CHECK.
- PID_CHECK: PID_CHECK_EN and pid_q[7:4] != ~pid_q[3:0] -> ERR with code 2; otherwise -> DATA_WAIT.
- DATA_WAIT: on shift_en, ~eop -> DATA_RCV; eop -> EOP.
- DATA_RCV: eop&&shift_en -> ERR_EOP with code 3. Otherwise byte_rcvd with byte_cnt == MAX_DATA_BYTES -> ERR with code 4. Otherwise byte_rcvd -> DATA_WRITE.
- DATA_WRITE: byte_cnt increments (saturating); always -> DATA_WAIT.
- EOP: d_edge -> IDLE.
- ERR: eop&&shift_en -> ERR_EOP.
- ERR_EOP: d_edge -> ERR_IDLE.
- ERR_IDLE: d_edge -> SYNC.

Timeout:
- The counter clears on shift_en and in every state other than SYNC, PID_WAIT, PID_RCV, DATA_WAIT and DATA_RCV.
- In those five states, when it reaches TIMEOUT_CYCLES-1 with no shift_en in the current cycle: -> ERR_IDLE with code 5.
- Priority within a cycle: early EOP, then byte/SYNC/overflow events, then timeout.

Status registers:
- err_code is written only on error transitions.
- err_code, byte_cnt and pid_q all clear on every entry to SYNC.
- The first error of a packet wins; later error transitions before the next SYNC do not overwrite err_code.

Outputs (Moore, decoded from state):
- rcving = 0 in IDLE, EOP, ERR_EOP and ERR_IDLE; 1 otherwise.
- w_enable = (DATA_WRITE).
- pid_set = (PID_WRITE).
- pid_rst = (SYNC).
- r_error = (ERR, ERR_EOP, ERR_IDLE).
- pid = pid_q[3:0].
- pkt_done is registered: high for exactly the first cycle in EOP.

## Timing
- Reset (rst sampled high at posedge): state IDLE; all outputs 0; err_code 0; byte_cnt 0; pid 0. Reset overrides all inputs and aborts any packet mid-stream with no pulse or error code.
- The FIFO write lands one cycle after byte_rcvd; rcv_data must still be valid then.
- PID check latency: 2 cycles after the PID byte_rcvd (PID_WRITE, then PID_CHECK).
- A zero-data packet (EOP right after the PID) is legal: byte_cnt 0, pkt_done 1.
- The overflow check uses byte_cnt before the increment, so exactly MAX_DATA_BYTES bytes are accepted.
- Timeout fires at the posedge ending the TIMEOUT_CYCLES-th consecutive cycle without shift_en.

## Test plan
- Valid packet, SYNC 0x80, PID 0xC3, data 0x11 and 0x22, EOP -> two w_enable pulses, pid=3, byte_cnt=2, one-cycle pkt_done, err_code 0, r_error never high.
- SYNC byte 0x81 -> ERR, r_error=1, err_code=1. A following eop&&shift_en, d_edge, d_edge then returns to SYNC with err_code cleared.
- PID 0xC4 with PID_CHECK_EN=1 -> err_code=2 and no w_enable. The same PID with PID_CHECK_EN=0 proceeds to DATA_WAIT.
- MAX_DATA_BYTES=4, six data bytes -> four w_enable pulses, fifth byte_rcvd -> ERR with err_code=4, byte_cnt holds 4.
- TIMEOUT_CYCLES=16, shift_en stopped in DATA_WAIT -> ERR_IDLE 16 cycles later, err_code=5, rcving=0. Separately, eop&&shift_en mid-byte in DATA_RCV -> ERR_EOP with err_code=3.
- rst asserted in DATA_RCV -> next cycle IDLE, all outputs 0. A subsequent valid packet completes normally.
